hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
Hazard and stall controller for the 5-stage MIPS pipeline. It compares the source registers of the instruction in D against the destinations of the in-flight E and M instructions using Tuse/Tnew, and it tracks the busy period of the multi-cycle mult/div unit. It drives the PC hold, the IF/ID hold and the ID/EX flush (the Reset_E input of the ID/EX register), so that a bubble enters E whenever D cannot proceed.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Rs_D  in  5  rs of D instruction
Rt_D  in  5  rt of D instruction
Tuse_Rs_D  in  2  cycles until rs is needed; 3 = rs unused
Tuse_Rt_D  in  2  cycles until rt is needed; 3 = rt unused
Dst_E  in  5  destination register of E instruction
Tnew_E  in  2  cycles until E result is available
RegWrite_E  in  1  E instruction writes the GPR file
Dst_M  in  5  destination register of M instruction
Tnew_M  in  2  cycles until M result is available
RegWrite_M  in  1  M instruction writes the GPR file
MdStart_E  in  1  mult/div in E this cycle (1-cycle pulse)
MdIsDiv_E  in  1  1 = div/divu, 0 = mult/multu; valid with MdStart_E
MdUse_D  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div
Stall_F  out  1  hold PC
Stall_D  out  1  hold IF/ID register
Flush_E  out  1  clear ID/EX next edge (to Reset_E)
MdBusy  out  1  mult/div unit busy
MdCount  out  4  remaining busy cycles

Behaviour:
- Data hazard on rs: hz_rs = (Rs_D != 0) & ((RegWrite_E & Dst_E == Rs_D & Tuse_Rs_D < Tnew_E) | (RegWrite_M & Dst_M == Rs_D & Tuse_Rs_D < Tnew_M)).
- Data hazard on rt: hz_rt is the same expression using Rt_D and Tuse_Rt_D.
- Tuse = 3 never stalls, because Tnew is at most 3.
- Register $0 never stalls.
- All comparisons are unsigned 2-bit.
- MDU hazard: md_stall = MdUse_D & (MdStart_E | MdBusy).
- stall = hz_rs | hz_rt | md_stall. This is combinational, with zero-cycle latency.
- Stall_F = Stall_D = Flush_E = stall & ~reset.
- MDU FSM has two states, IDLE and BUSY, both registered:
  - IDLE & MdStart_E -> BUSY, MdCount <= MdIsDiv_E ? DIV_CYCLES : MULT_CYCLES.
  - BUSY & MdCount > 1 -> BUSY, MdCount <= MdCount - 1.
  - BUSY & MdCount == 1 -> IDLE, MdCount <= 0.
  - BUSY & MdStart_E (not reachable under correct stalling) -> restart: reload MdCount per MdIsDiv_E and stay BUSY. MdStart_E wins over the decrement.
- MdBusy = (state == BUSY). It rises on the edge after MdStart_E and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
- MdStart_E in the same cycle as Flush_E is still accepted, because it belongs to the E instruction, which is not flushed.
- Reset, synchronous at the edge with reset = 1:
  - state <= IDLE, MdCount <= 0, MdBusy = 0.
  - While reset is high, Stall_F, Stall_D and Flush_E are forced to 0.
  - Reset in mid-BUSY aborts the operation; the next cycle shows MdBusy = 0, MdCount = 0.
- Reset values: Stall_F = Stall_D = Flush_E = 0, MdBusy = 0, MdCount = 0.

Optional Feature:
- Macro STALL_CNT_EN.
- When defined, adds output StallCount [31:0]: a register incremented on every edge where stall = 1 and reset = 0. It saturates at 32'hFFFFFFFF and is cleared to 0 by reset.
- When undefined, the port and the register are absent and the remaining behaviour is identical.

Test Plan:
- Load-use: Dst_E = 1, RegWrite_E = 1, Tnew_E = 2, Rs_D = 1, Tuse_Rs_D = 1 -> Stall_F = Stall_D = Flush_E = 1. Next cycle Dst_M = 1, Tnew_M = 1, E bubble -> stall = 0.
- $0 and unused operands: Dst_E = 0, Tnew_E = 2, Rs_D = 0, Tuse_Rs_D = 0 -> stall 0. Then Rt_D = Dst_E = 5, Tuse_Rt_D = 3 -> stall 0.
- Branch: Rs_D = Dst_M = 7, RegWrite_M = 1, Tnew_M = 1, Tuse_Rs_D = 0 -> stall 1. Same with RegWrite_M = 0 -> stall 0.
- Mult: MdStart_E = 1, MdIsDiv_E = 0, MdUse_D = 1 -> stall 1 that cycle. Then MdBusy = 1 with MdCount 5, 4, 3, 2, 1 over 5 cycles, stall 1 throughout. Then MdBusy = 0, MdCount = 0, stall 0.
- Div with reset: MdStart_E, MdIsDiv_E = 1 -> MdCount 10, 9, 8. Assert reset for 1 cycle -> next cycle MdBusy = 0, MdCount = 0, all stall outputs 0 during reset.
- STALL_CNT_EN: 3 load-use stall cycles, then 2 clean cycles -> StallCount = 3. Reset -> 0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: D/E/M operand info in, stall controls out.
// The optional StallCount output (macro STALL_CNT_EN) is a plain port on the controller, not part of this bundle.
interface hazard_stall_ctrl_if;
  logic [4:0] Rs_D;
  logic [4:0] Rt_D;
  logic [1:0] Tuse_Rs_D;
  logic [1:0] Tuse_Rt_D;
  logic [4:0] Dst_E;
  logic [1:0] Tnew_E;
  logic       RegWrite_E;
  logic [4:0] Dst_M;
  logic [1:0] Tnew_M;
  logic       RegWrite_M;
  logic       MdStart_E;
  logic       MdIsDiv_E;
  logic       MdUse_D;
  logic       Stall_F;
  logic       Stall_D;
  logic       Flush_E;
  logic       MdBusy;
  logic [3:0] MdCount;

  modport master (
    output Rs_D, Rt_D, Tuse_Rs_D, Tuse_Rt_D, Dst_E, Tnew_E, RegWrite_E,
    output Dst_M, Tnew_M, RegWrite_M, MdStart_E, MdIsDiv_E, MdUse_D,
    input  Stall_F, Stall_D, Flush_E, MdBusy, MdCount
  );

  modport slave (
    input  Rs_D, Rt_D, Tuse_Rs_D, Tuse_Rt_D, Dst_E, Tnew_E, RegWrite_E,
    input  Dst_M, Tnew_M, RegWrite_M, MdStart_E, MdIsDiv_E, MdUse_D,
    output Stall_F, Stall_D, Flush_E, MdBusy, MdCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew hazard detection plus mult/div busy tracking for the 5-stage MIPS pipeline.
// Optional macro STALL_CNT_EN adds a saturating 32-bit StallCount output.
module hazard_stall_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                reset,
`ifdef STALL_CNT_EN
  output logic [31:0]         StallCount,
`endif
  hazard_stall_ctrl_if.slave  hif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t  state_reg;
  logic [3:0] count_reg;

  // Operand 0 is rs, operand 1 is rt; both use the same hazard rule.
  logic [1:0][4:0] src_d;
  logic [1:0][1:0] tuse_d;
  logic [1:0]      hz;
  logic            md_stall;
  logic            stall;

  assign src_d[0]  = hif.Rs_D;
  assign src_d[1]  = hif.Rt_D;
  assign tuse_d[0] = hif.Tuse_Rs_D;
  assign tuse_d[1] = hif.Tuse_Rt_D;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      assign hz[gi] = (src_d[gi] != 5'd0) &
                      ((hif.RegWrite_E & (hif.Dst_E == src_d[gi]) & (tuse_d[gi] < hif.Tnew_E)) |
                       (hif.RegWrite_M & (hif.Dst_M == src_d[gi]) & (tuse_d[gi] < hif.Tnew_M)));
    end
  endgenerate

  assign md_stall = hif.MdUse_D & (hif.MdStart_E | (state_reg == BUSY));
  assign stall    = |hz | md_stall;

  assign hif.Stall_F = stall & ~reset;
  assign hif.Stall_D = stall & ~reset;
  assign hif.Flush_E = stall & ~reset;
  assign hif.MdBusy  = (state_reg == BUSY);
  assign hif.MdCount = count_reg;

  // A start always reloads, even when already busy; it belongs to E, which is never flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else if (hif.MdStart_E) begin
      state_reg <= BUSY;
      count_reg <= hif.MdIsDiv_E ? DIV_LOAD : MULT_LOAD;
    end else if (state_reg == BUSY) begin
      if (count_reg > 4'd1) begin
        count_reg <= count_reg - 4'd1;
      end else begin
        state_reg <= IDLE;
        count_reg <= 4'd0;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
    end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign StallCount = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: data hazards, $0/unused operands, mult/div busy, reset abort.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl_if hif ();

`ifdef STALL_CNT_EN
  logic [31:0] StallCount;
`endif

  hazard_stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef STALL_CNT_EN
    .StallCount (StallCount),
`endif
    .hif        (hif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs then change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.Rs_D = 5'd0; hif.Rt_D = 5'd0; hif.Tuse_Rs_D = 2'd3; hif.Tuse_Rt_D = 2'd3;
    hif.Dst_E = 5'd0; hif.Tnew_E = 2'd0; hif.RegWrite_E = 1'b0;
    hif.Dst_M = 5'd0; hif.Tnew_M = 2'd0; hif.RegWrite_M = 1'b0;
    hif.MdStart_E = 1'b0; hif.MdIsDiv_E = 1'b0; hif.MdUse_D = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    #1;
    check({tag, ".Stall_F"}, 32'(hif.Stall_F), 32'(exp));
    check({tag, ".Stall_D"}, 32'(hif.Stall_D), 32'(exp));
    check({tag, ".Flush_E"}, 32'(hif.Flush_E), 32'(exp));
  endtask

  task automatic check_md(input string tag, input logic busy, input logic [3:0] cnt);
    check({tag, ".MdBusy"},  32'(hif.MdBusy),  32'(busy));
    check({tag, ".MdCount"}, 32'(hif.MdCount), 32'(cnt));
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    check_md("reset", 1'b0, 4'd0);
    // A load-use pattern while reset is high must not stall.
    hif.Rs_D = 5'd1; hif.Tuse_Rs_D = 2'd1;
    hif.Dst_E = 5'd1; hif.Tnew_E = 2'd2; hif.RegWrite_E = 1'b1;
    check_stall("reset_forced", 1'b0);
    reset = 1'b0;
    check_stall("load_use", 1'b1);
    tick();

    // Loaded value now in M with one cycle left, bubble in E.
    hif.Dst_E = 5'd0; hif.Tnew_E = 2'd0; hif.RegWrite_E = 1'b0;
    hif.Dst_M = 5'd1; hif.Tnew_M = 2'd1; hif.RegWrite_M = 1'b1;
    check_stall("load_use_resolved", 1'b0);
    tick();

    clear_inputs();
    hif.Dst_E = 5'd0; hif.Tnew_E = 2'd2; hif.RegWrite_E = 1'b1;
    hif.Rs_D = 5'd0; hif.Tuse_Rs_D = 2'd0;
    check_stall("reg0", 1'b0);
    hif.Dst_E = 5'd5; hif.Rt_D = 5'd5; hif.Tuse_Rt_D = 2'd3;
    check_stall("rt_unused", 1'b0);
    hif.Tuse_Rt_D = 2'd1;
    check_stall("rt_hazard", 1'b1);
    hif.Tuse_Rt_D = 2'd2;
    check_stall("rt_tuse_eq_tnew", 1'b0);
    tick();

    clear_inputs();
    hif.Rs_D = 5'd7; hif.Tuse_Rs_D = 2'd0;
    hif.Dst_M = 5'd7; hif.Tnew_M = 2'd1; hif.RegWrite_M = 1'b1;
    check_stall("branch_m", 1'b1);
    hif.RegWrite_M = 1'b0;
    check_stall("branch_no_write", 1'b0);
    tick();

    // Mult: stall in the start cycle, then 5 busy cycles.
    clear_inputs();
    hif.MdStart_E = 1'b1; hif.MdIsDiv_E = 1'b0; hif.MdUse_D = 1'b1;
    check_stall("mult_start", 1'b1);
    check_md("mult_start", 1'b0, 4'd0);
    tick();
    hif.MdStart_E = 1'b0;
    for (int k = 5; k >= 1; k--) begin
      check_md($sformatf("mult_busy%0d", k), 1'b1, 4'(k));
      check_stall($sformatf("mult_busy%0d", k), 1'b1);
      tick();
    end
    check_md("mult_done", 1'b0, 4'd0);
    check_stall("mult_done", 1'b0);
    tick();

    // Div, aborted by reset after reaching 8.
    hif.MdUse_D = 1'b0;
    hif.MdStart_E = 1'b1; hif.MdIsDiv_E = 1'b1;
    tick();
    hif.MdStart_E = 1'b0;
    check_md("div10", 1'b1, 4'd10);
    tick();
    check_md("div9", 1'b1, 4'd9);
    tick();
    check_md("div8", 1'b1, 4'd8);
    check_stall("div_no_use", 1'b0);
    hif.MdUse_D = 1'b1;
    reset = 1'b1;
    check_stall("div_reset_forced", 1'b0);
    tick();
    reset = 1'b0;
    check_md("div_aborted", 1'b0, 4'd0);
    check_stall("div_aborted", 1'b0);

    // Start while busy reloads with the new length.
    hif.MdUse_D = 1'b0;
    hif.MdStart_E = 1'b1; hif.MdIsDiv_E = 1'b0;
    tick();
    check_md("restart_mult", 1'b1, 4'd5);
    hif.MdIsDiv_E = 1'b1;
    tick();
    hif.MdStart_E = 1'b0;
    check_md("restart_div", 1'b1, 4'd10);
    tick();
    check_md("restart_dec", 1'b1, 4'd9);

`ifdef STALL_CNT_EN
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
    check("stallcnt_reset", StallCount, 32'd0);
    hif.Rs_D = 5'd1; hif.Tuse_Rs_D = 2'd1;
    hif.Dst_E = 5'd1; hif.Tnew_E = 2'd2; hif.RegWrite_E = 1'b1;
    repeat (3) tick();
    clear_inputs();
    repeat (2) tick();
    check("stallcnt_3", StallCount, 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("stallcnt_cleared", StallCount, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
